alu_result_buffer: RTL and testbench
====================================

// Module: alu_result_buffer
// PURPOSE
// - Downstream stage of the 32-bit integer ALU: captures {opcode, result, carry-out} from the ALU multiplexer output.
// - Derives status flags and queues the entries in a DEPTH-entry FIFO behind valid/ready handshakes.
// - Decouples the combinational ALU from the consumer (register file / writeback).
// - Holds each result stable until the consumer accepts it.
// PARAMETERS
// - WIDTH  32  result data width
// - DEPTH  4   FIFO entries; power of two, >= 2
// - CNT_W  3   width of occupancy count; = log2(DEPTH)+1
// PORTS
// - clk         in   1      sole clock, rising edge
// - rst         in   1      asynchronous, active-high reset
// - in_valid    in   1      ALU entry present this cycle
// - in_ready    out  1      buffer can accept an entry
// - in_op       in   3      ALU choice code that produced in_result
// - in_result   in   WIDTH  ALU result
// - in_cout     in   1      adder carry-out
// - out_valid   out  1      head entry valid
// - out_ready   in   1      consumer accepts head entry
// - out_op      out  3      head opcode
// - out_result  out  WIDTH  head result
// - out_flags   out  4      head flags {C,E,N,Z}
// - out_count   out  CNT_W  current occupancy, 0..DEPTH
// BEHAVIOUR
// - Interface: one clock (clk); asynchronous active-high reset (rst). All state clears immediately on rst assertion.
// - Reset state: count=0, rd_ptr=wr_ptr=0, out_valid=0, out_op=0, out_result=0, out_flags=0, out_count=0.
//   in_ready=0 while rst=1, and 1 from the first cycle after release.
// - Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are sampled at the rising edge of clk.
// - in_ready = (count < DEPTH). It is a function of registered count only and never of out_ready.
//   There is no pass-through when the buffer is full.
// - Latency: an entry pushed at edge N appears on out_* with out_valid=1 after edge N, when the buffer was empty.
//   out_* is first-word-fall-through from storage, not a separate pipeline register.
// - out_* holds constant while out_valid=1 and out_ready=0.
// - Outputs while empty: out_valid=0. out_result, out_op and out_flags show the last-read slot; consumers ignore them.
// - Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
// - Pointers increment modulo DEPTH. wr_ptr wraps from DEPTH-1 to 0 with no bubble.
// - Full: in_ready=0 and in_valid is ignored. A pop in that cycle makes in_ready=1 on the next cycle.
// - Empty: out_ready is ignored and count does not underflow.
// - Flags are computed at push time from in_*. They are stored with the entry.
//   - Z = (in_result == 0)
//   - N = in_result[WIDTH-1]
//   - C = in_cout when in_op==ADD, else 0
//   - E = in_result[0] when in_op==CMP (equal indicator of compare code {gt,lt,eq}), else 0
// - Reset asserted mid-operation discards all queued entries. No partial state survives.
// - No states other than occupancy. count is the only control register; no FSM beyond the pointers.
// STRUCTURE
// - Shared package alu_pkg holds:
//   - opcode constants AND=0, OR=1, ADD=2, ONES=3, TWOS=4, SUB=5, MUL=6, CMP=7
//   - flag bit indices Z=0, N=1, E=2, C=3
//   - compare encodings GT=3'b100, LT=3'b010, EQ=3'b001
// - One sub-module: alu_flag_gen. It is combinational, in_op/in_result/in_cout -> 4-bit flags.
// - Storage: DEPTH x (3+WIDTH+4) register array, written at wr_ptr and read at rd_ptr.
// TESTING
// - Reset: assert rst mid-cycle with 3 entries queued.
//   -> out_valid=0 and out_count=0 immediately; in_ready=1 one cycle after release.
// - Single push: op=ADD, result=0x0000_0000, cout=1.
//   -> next cycle out_valid=1, out_flags=4'b1001 (C,Z), out_count=1.
// - Fill: push 4 entries with out_ready=0.
//   -> in_ready=0 and out_count=4; a fifth in_valid is dropped; FIFO order is preserved on drain.
// - Concurrent push/pop at count=2 for 10 cycles.
//   -> out_count stays 2; results emerge in push order across the pointer wrap.
// - Flags: op=CMP with result=0x1 -> E=1. op=SUB with result=0x8000_0000 and cout=1 -> N=1, C=0.
// - Backpressure: random out_ready with 1000 pushes.
//   -> the scoreboard matches every result and opcode; no loss and no duplication.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status-flag bit positions and
// compare-result encodings used by the ALU and its downstream stages.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_ADD  = 3'd2,
        OP_ONES = 3'd3,
        OP_TWOS = 3'd4,
        OP_SUB  = 3'd5,
        OP_MUL  = 3'd6,
        OP_CMP  = 3'd7
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_E = 2;
    localparam int FLAG_C = 3;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation for one ALU result: {C,E,N,Z}.
// Carry is only meaningful for ADD and the equal bit only for CMP.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    output logic [3:0]       flags
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (in_result == '0);
        flags[FLAG_N] = in_result[WIDTH-1];
        flags[FLAG_C] = (in_op == OP_ADD) && in_cout;
        // a CMP result is the one-hot {gt,lt,eq}; bit 0 is the equal indicator
        flags[FLAG_E] = (in_op == OP_CMP) && in_result[0];
    end

endmodule

// File: rtl/alu_result_buffer.sv
// First-word-fall-through FIFO that captures ALU results with their flags and
// hands them to the writeback consumer behind valid/ready handshakes.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] out_count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_sel;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       in_flags;
    logic             push;
    logic             pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .in_op     (in_op),
        .in_result (in_result),
        .in_cout   (in_cout),
        .flags     (in_flags)
    );

    // readiness depends on stored occupancy only, so a full buffer never passes through
    assign in_ready  = !rst && (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{op: in_op, result: in_result, flags: in_flags};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // while empty, keep presenting the slot that was read last
    assign rd_sel     = out_valid ? rd_ptr_q : rd_ptr_q - PTR_W'(1);
    assign out_op     = mem_q[rd_sel].op;
    assign out_result = mem_q[rd_sel].result;
    assign out_flags  = mem_q[rd_sel].flags;
    assign out_count  = count_q;

    // NOTE: the storage array is reset because the outputs read it directly and must be zero out of reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: flag vector table, directed
// multi-cycle corner cases and a scoreboard that checks every popped entry.
module tb_alu_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_result;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_op;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
    } sb_entry_t;

    sb_entry_t sb[$];

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] result;
        logic             cout;
        logic [3:0]       exp_flags;
    } vec_t;

    vec_t vecs[9];

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference flags {C,E,N,Z}: ADD=2 carries, CMP=7 reports bit 0 as equal.
    function automatic logic [3:0] model_flags(input logic [2:0] op, input logic [WIDTH-1:0] r,
                                               input logic cout);
        logic c, e, n, z;
        z = (r == 0);
        n = r[WIDTH-1];
        c = (op == 3'd2) ? cout : 1'b0;
        e = (op == 3'd7) ? r[0] : 1'b0;
        return {c, e, n, z};
    endfunction

    // Scoreboard: handshakes are predicted at the falling edge, inputs are stable then.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_pop", {61'd0, out_op}, 64'hFFFF);
                end else begin
                    sb_entry_t e;
                    e = sb.pop_front();
                    check("sb_entry", {25'd0, out_op, out_result, out_flags},
                          {25'd0, e.op, e.result, e.flags});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{op: in_op, result: in_result,
                               flags: model_flags(in_op, in_result, in_cout)});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] r, input logic c);
        in_valid  = 1'b1;
        in_op     = op;
        in_result = r;
        in_cout   = c;
    endtask

    initial begin
        int pushes;
        int cyc;

        vecs[0] = '{3'd2, 32'h0000_0000, 1'b1, 4'b1001};
        vecs[1] = '{3'd7, 32'h0000_0001, 1'b0, 4'b0100};
        vecs[2] = '{3'd5, 32'h8000_0000, 1'b1, 4'b0010};
        vecs[3] = '{3'd2, 32'hFFFF_FFFF, 1'b1, 4'b1010};
        vecs[4] = '{3'd2, 32'h0000_0005, 1'b0, 4'b0000};
        vecs[5] = '{3'd0, 32'h0000_0000, 1'b1, 4'b0001};
        vecs[6] = '{3'd7, 32'h0000_0004, 1'b1, 4'b0000};
        vecs[7] = '{3'd7, 32'h0000_0000, 1'b0, 4'b0001};
        vecs[8] = '{3'd1, 32'h8000_0001, 1'b1, 4'b0010};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_result = '0;
        in_cout   = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        check("rst_in_ready",   {63'd0, in_ready}, 64'd0);
        check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
        check("rst_out_count",  {61'd0, out_count}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        check("rst_out_op",     {61'd0, out_op}, 64'd0);
        check("rst_out_flags",  {60'd0, out_flags}, 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        next_cycle();

        // single push: ADD of zero with carry
        drive(3'd2, 32'h0, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("single_out_valid", {63'd0, out_valid}, 64'd1);
        check("single_out_flags", {60'd0, out_flags}, 64'b1001);
        check("single_out_count", {61'd0, out_count}, 64'd1);
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;

        // flag vector table, one entry at a time
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].op, vecs[i].result, vecs[i].cout);
            next_cycle();
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_flags", i), {60'd0, out_flags}, {60'd0, vecs[i].exp_flags});
            check($sformatf("vec%0d_result", i), {32'd0, out_result}, {32'd0, vecs[i].result});
            check($sformatf("vec%0d_count", i), {61'd0, out_count}, 64'd1);
            next_cycle();
            out_ready = 1'b1;
            next_cycle();
            out_ready = 1'b0;
        end

        // fill to DEPTH, fifth push dropped, head held under backpressure
        for (int i = 0; i < DEPTH; i++) begin
            drive(3'(i), 32'hA0 + 32'(i), 1'b0);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_count",    {61'd0, out_count}, 64'd4);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_head",     {32'd0, out_result}, 64'hA0);
        next_cycle();
        drive(3'd6, 32'hDEAD_BEEF, 1'b0);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("full_drop_count", {61'd0, out_count}, 64'd4);
        check("full_hold_head",  {32'd0, out_result}, 64'hA0);
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("unfull_in_ready", {63'd0, in_ready}, 64'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        check("drain_count", {61'd0, out_count}, 64'd0);
        check("drain_valid", {63'd0, out_valid}, 64'd0);
        next_cycle();

        // concurrent push/pop at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(3'd1, 32'hB0 + 32'(i), 1'b0);
            next_cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drive(3'(i % 8), 32'hC0 + 32'(i), 1'b1);
            out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("conc_count%0d", i), {61'd0, out_count}, 64'd2);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("conc_end_count", {61'd0, out_count}, 64'd2);
        next_cycle();
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        check("conc_drained", {61'd0, out_count}, 64'd0);
        next_cycle();

        // reset asserted mid-cycle with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            drive(3'd4, 32'hE0 + 32'(i), 1'b0);
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_count", {61'd0, out_count}, 64'd0);
        check("midrst_in_ready",  {63'd0, in_ready}, 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_release_count", {61'd0, out_count}, 64'd0);
        next_cycle();

        // random traffic with random backpressure until 1000 pushes are accepted
        pushes = 0;
        cyc    = 0;
        while (pushes < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_result = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            in_cout   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) pushes++;
            next_cycle();
            cyc++;
        end
        check("rand_pushes", 64'(pushes), 64'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (out_count != 0 && cyc < 20) begin
            next_cycle();
            cyc++;
        end
        @(negedge clk);
        check("rand_drain_count", {61'd0, out_count}, 64'd0);
        check("rand_sb_empty",    64'(sb.size()), 64'd0);
        out_ready = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
